lfsr_checker: RTL and testbench

Synthesizable receive-side checker for the team's 32-bit XNOR LFSR pattern (taps 32,22,2,1, default seed 32'hAE1F_B42C). Each `in_valid` beat carries one full 32-bit LFSR state, the same word the bench generator returns per step. The block self-synchronises to the incoming stream, declares lock, then counts mismatching words. It sits at the far end of any datapath (FIFO, link, memory loop-back) fed by the generator, so long random-traffic runs can be checked in hardware without a scoreboard.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_checker.sv | 129 ++++++++++++
 tb/tb_lfsr_checker.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit XNOR LFSR pattern (taps 32,22,2,1).
// The generator and the checker both call lfsr_next, so the polynomial is defined once.
package lfsr_pkg;

  localparam int unsigned LFSR_W      = 32;
  localparam logic [LFSR_W-1:0] LFSR_SEED   = 32'hAE1F_B42C;
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~^{s[31], s[21], s[1], s[0]}};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to the incoming word stream,
// declares lock, then counts mismatching and checked words while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned SYNC_LEN = 4,
  parameter int unsigned LOSS_LEN = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int unsigned MATCH_W = (SYNC_LEN > 2) ? $clog2(SYNC_LEN) : 1;
  localparam int unsigned MISS_W  = (LOSS_LEN > 2) ? $clog2(LOSS_LEN) : 1;

  chk_state_e         state_q, state_d;
  logic [LFSR_W-1:0]  exp_q, exp_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               hit_c;
  logic               lockup_c;

  assign hit_c    = (in_data == exp_q);
  assign lockup_c = (in_data == LFSR_LOCKUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      exp_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // Next-state: sync search, reseed on SYNC mismatch, free-running exp while locked.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (in_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (!lockup_c) begin
            exp_d       = lfsr_next(in_data);
            match_cnt_d = '0;
            state_d     = SYNC;
          end
        end
        SYNC: begin
          if (hit_c) begin
            exp_d = lfsr_next(exp_q);
            if (match_cnt_q == MATCH_W'(SYNC_LEN - 1)) begin
              match_cnt_d = '0;
              miss_cnt_d  = '0;
              state_d     = LOCKED;
            end else begin
              match_cnt_d = match_cnt_q + MATCH_W'(1);
            end
          end else if (lockup_c) begin
            match_cnt_d = '0;
            state_d     = SEARCH;
          end else begin
            exp_d       = lfsr_next(in_data);
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          exp_d = lfsr_next(exp_q);
          if (hit_c) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q == MISS_W'(LOSS_LEN - 1)) begin
            miss_cnt_d = '0;
            state_d    = SEARCH;
          end else begin
            miss_cnt_d = miss_cnt_q + MISS_W'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Outputs: clear takes effect before a same-cycle increment; counters saturate.
  always_comb begin
    locked_d    = (state_d == LOCKED);
    err_pulse_d = 1'b0;
    err_cnt_d   = clr ? '0 : err_cnt_q;
    word_cnt_d  = clr ? '0 : word_cnt_q;
    if (in_valid && (state_q == LOCKED)) begin
      if (word_cnt_d != '1) word_cnt_d = word_cnt_d + CNT_W'(1);
      if (!hit_c) begin
        err_pulse_d = 1'b1;
        if (err_cnt_d != '1) err_cnt_d = err_cnt_d + CNT_W'(1);
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: default instance plus a CNT_W=4/LOSS_LEN=32 instance,
// both compared every cycle against a behavioural model of the lock rules.
module tb_lfsr_checker;
  import lfsr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;

  logic        locked_a, err_pulse_a;
  logic [15:0] err_cnt_a, word_cnt_a;
  logic        locked_b, err_pulse_b;
  logic [3:0]  err_cnt_b, word_cnt_b;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  lfsr_checker #(.SYNC_LEN(4), .LOSS_LEN(8), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .locked(locked_a), .err_pulse(err_pulse_a), .err_cnt(err_cnt_a), .word_cnt(word_cnt_a));

  lfsr_checker #(.SYNC_LEN(4), .LOSS_LEN(32), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .locked(locked_b), .err_pulse(err_pulse_b), .err_cnt(err_cnt_b), .word_cnt(word_cnt_b));

  // Model: mode 0 hunting, 1 confirming, 2 locked; counts kept as plain integers.
  int          m_sync [2] = '{4, 4};
  int          m_loss [2] = '{8, 32};
  int          m_cmax [2] = '{65535, 15};
  int          m_mode [2];
  int          m_run  [2];
  int          m_miss [2];
  int          m_errs [2];
  int          m_words[2];
  bit          m_pulse[2];
  logic [31:0] m_exp  [2];
  logic [31:0] gen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_run[k] = 0; m_miss[k] = 0;
      m_errs[k] = 0; m_words[k] = 0; m_pulse[k] = 1'b0; m_exp[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input bit v, input logic [31:0] d, input bit c);
    m_pulse[k] = 1'b0;
    if (c) begin
      m_errs[k] = 0;
      m_words[k] = 0;
    end
    if (!v) return;
    if (m_mode[k] == 0) begin
      if (d != LFSR_LOCKUP) begin
        m_exp[k] = lfsr_next(d);
        m_run[k] = 0;
        m_mode[k] = 1;
      end
    end else if (m_mode[k] == 1) begin
      if (d == m_exp[k]) begin
        m_exp[k] = lfsr_next(m_exp[k]);
        m_run[k]++;
        if (m_run[k] == m_sync[k]) begin
          m_mode[k] = 2;
          m_miss[k] = 0;
        end
      end else if (d == LFSR_LOCKUP) begin
        m_mode[k] = 0;
      end else begin
        m_exp[k] = lfsr_next(d);
        m_run[k] = 0;
      end
    end else begin
      m_words[k] = (m_words[k] + 1 > m_cmax[k]) ? m_cmax[k] : m_words[k] + 1;
      if (d != m_exp[k]) begin
        m_pulse[k] = 1'b1;
        m_errs[k] = (m_errs[k] + 1 > m_cmax[k]) ? m_cmax[k] : m_errs[k] + 1;
        m_miss[k]++;
        if (m_miss[k] == m_loss[k]) m_mode[k] = 0;
      end else begin
        m_miss[k] = 0;
      end
      m_exp[k] = lfsr_next(m_exp[k]);
    end
  endtask

  task automatic compare_all();
    check("a_locked",    32'(locked_a),    32'(m_mode[0] == 2));
    check("a_err_pulse", 32'(err_pulse_a), 32'(m_pulse[0]));
    check("a_err_cnt",   32'(err_cnt_a),   32'(m_errs[0]));
    check("a_word_cnt",  32'(word_cnt_a),  32'(m_words[0]));
    check("b_locked",    32'(locked_b),    32'(m_mode[1] == 2));
    check("b_err_pulse", 32'(err_pulse_b), 32'(m_pulse[1]));
    check("b_err_cnt",   32'(err_cnt_b),   32'(m_errs[1]));
    check("b_word_cnt",  32'(word_cnt_b),  32'(m_words[1]));
  endtask

  task automatic cycle(input bit v, input logic [31:0] d, input bit c);
    @(negedge clk);
    in_valid = v; in_data = d; clr = c;
    model_step(0, v, d, c);
    model_step(1, v, d, c);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic good_beat();
    cycle(1'b1, gen, 1'b0);
    gen = lfsr_next(gen);
  endtask

  task automatic bad_beat(input logic [31:0] d);
    cycle(1'b1, d, 1'b0);
    gen = lfsr_next(gen);
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear without waiting for clk.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0; clr = 1'b0;
    #1;
    model_reset();
    check("rst_locked", 32'(locked_a), 32'd0);
    check("rst_err_pulse", 32'(err_pulse_a), 32'd0);
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #10ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_locked",   32'(locked_a),   32'd0);
    check("reset_err_cnt",  32'(err_cnt_a),  32'd0);
    check("reset_word_cnt", 32'(word_cnt_a), 32'd0);
    compare_all();
    rst_n = 1'b1;

    // Clean stream from the seed: lock after beat 5, then 100 error-free words.
    gen = LFSR_SEED;
    repeat (4) good_beat();
    check("lock_not_yet", 32'(locked_a), 32'd0);
    good_beat();
    check("lock_beat5", 32'(locked_a), 32'd1);
    repeat (100) good_beat();
    check("clean_words", 32'(word_cnt_a), 32'd100);
    check("clean_errs",  32'(err_cnt_a),  32'd0);

    // Single corrupt word gives exactly one error.
    bad_beat(gen ^ 32'h1);
    check("flip_pulse",  32'(err_pulse_a), 32'd1);
    check("flip_errs",   32'(err_cnt_a),   32'd1);
    check("flip_locked", 32'(locked_a),    32'd1);
    repeat (10) good_beat();
    check("flip_after_errs", 32'(err_cnt_a), 32'd1);

    // Eight zero words drop lock; resumed stream relocks after five beats.
    cycle(1'b0, '0, 1'b1);
    repeat (7) bad_beat('0);
    check("loss_still_locked", 32'(locked_a), 32'd1);
    bad_beat('0);
    check("loss_dropped", 32'(locked_a),  32'd0);
    check("loss_errs",    32'(err_cnt_a), 32'd8);
    repeat (4) good_beat();
    check("relock_not_yet", 32'(locked_a), 32'd0);
    good_beat();
    check("relock", 32'(locked_a), 32'd1);

    // All-ones never seeds; SYNC mismatch after two matches reseeds.
    mid_reset();
    repeat (10) cycle(1'b1, LFSR_LOCKUP, 1'b0);
    check("lockup_no_lock", 32'(locked_a), 32'd0);
    gen = LFSR_SEED;
    repeat (3) good_beat();
    gen = 32'h1234_5678;
    good_beat();
    repeat (3) good_beat();
    check("reseed_not_yet", 32'(locked_a), 32'd0);
    good_beat();
    check("reseed_lock", 32'(locked_a), 32'd1);

    // Saturation of the narrow instance, then clear coinciding with an error beat.
    cycle(1'b0, '0, 1'b1);
    repeat (20) bad_beat(gen ^ 32'h8000_0000);
    check("sat_errs_b",   32'(err_cnt_b), 32'd15);
    check("sat_locked_b", 32'(locked_b),  32'd1);
    cycle(1'b1, gen ^ 32'h1, 1'b1);
    gen = lfsr_next(gen);
    check("clr_err_b", 32'(err_cnt_b), 32'd1);

    // Reset mid-lock with gaps in valid, and idle cycles.
    gen = LFSR_SEED;
    mid_reset();
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 2) cycle(1'b0, $urandom, 1'b0);
      else good_beat();
    end
    check("gap_locked", 32'(locked_a), 32'd1);
    repeat (5) cycle(1'b0, $urandom, 1'b0);
    mid_reset();

    // Randomised traffic against the model.
    gen = $urandom;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 2) begin
        mid_reset();
      end else if (r < 200) begin
        cycle(1'b0, $urandom, ($urandom_range(0, 49) == 0));
      end else if (r < 230) begin
        cycle(1'b1, gen ^ (32'h1 << $urandom_range(0, 31)), ($urandom_range(0, 49) == 0));
        gen = lfsr_next(gen);
      end else if (r < 245) begin
        bad_beat(LFSR_LOCKUP);
      end else if (r < 255) begin
        bad_beat('0);
      end else if (r < 262) begin
        gen = lfsr_next(gen);
      end else begin
        cycle(1'b1, gen, ($urandom_range(0, 49) == 0));
        gen = lfsr_next(gen);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
